// File: rtl/io_read_port_fifo_if.sv
// Read-port bundle between the producer/predication side (master) and the I/O read FIFO (slave).
// The master drives the push handshake and io_rden; the slave returns flags, occupancy and the popped word.
interface io_read_port_fifo_if #(
   parameter int WORD_WIDTH = 36,
   parameter int ADDR_WIDTH = 2
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WORD_WIDTH-1:0] in_data;
   logic                  io_rden;
   logic                  read_EF;
   logic [WORD_WIDTH-1:0] read_data;
   logic [ADDR_WIDTH:0]   level;
   logic                  underflow;

   modport master (
      output in_valid, in_data, io_rden,
      input  in_ready, read_EF, read_data, level, underflow
   );

   modport slave (
      input  in_valid, in_data, io_rden,
      output in_ready, read_EF, read_data, level, underflow
   );
endinterface

// File: rtl/io_read_port_fifo.sv
// Per-port I/O read FIFO: push visible one edge later, pop lands on read_data after the io_rden edge; in_ready drops only when full.
// Optional sticky empty-pop flag under macro IO_READ_PORT_UNDERFLOW_EN (otherwise underflow is tied low).
module io_read_port_fifo #(
   parameter int WORD_WIDTH = 36,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   io_read_port_fifo_if.slave   port
);

   localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wp;
   logic [ADDR_WIDTH-1:0] rp;
   logic [ADDR_WIDTH:0]   level_q;
   logic [WORD_WIDTH-1:0] read_data_q;
   logic                  in_ready;
   logic                  push;
   logic                  pop;

   // Both flags come from the registered count only, so a full FIFO refuses a push even while popping.
   assign in_ready = (level_q != FULL_LEVEL);
   assign push     = port.in_valid && in_ready;
   assign pop      = port.io_rden && (level_q != '0);

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wp] <= port.in_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wp          <= '0;
         rp          <= '0;
         level_q     <= '0;
         read_data_q <= '0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp          <= rp + 1'b1;
            read_data_q <= mem[rp];
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

`ifdef IO_READ_PORT_UNDERFLOW_EN
   logic underflow_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         underflow_q <= 1'b0;
      end else if (port.io_rden && (level_q == '0)) begin
         underflow_q <= 1'b1;
      end
   end

   assign port.underflow = underflow_q;
`else
   assign port.underflow = 1'b0;
`endif

   assign port.in_ready  = in_ready;
   assign port.read_EF   = (level_q != '0);
   assign port.read_data = read_data_q;
   assign port.level     = level_q;

endmodule

// File: tb/tb_io_read_port_fifo.sv
// Directed bench for io_read_port_fifo: fill/drain, wrap, full and empty corner cases, mid-stream reset.
module tb_io_read_port_fifo;

   localparam int WW = 36;
   localparam int AW = 2;

`ifdef IO_READ_PORT_UNDERFLOW_EN
   localparam logic EXP_UF = 1'b1;
`else
   localparam logic EXP_UF = 1'b0;
`endif

   logic clock;
   logic reset_n;
   int   n_tests;
   int   n_fail;

   io_read_port_fifo_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

   io_read_port_fifo #(
      .WORD_WIDTH(WW),
      .DEPTH     (4),
      .ADDR_WIDTH(AW)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .port   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_word(input logic [WW-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic pop_word(input string tag, input logic [WW-1:0] exp_d);
      bus.io_rden = 1'b1;
      tick();
      bus.io_rden = 1'b0;
      chk(tag, bus.read_data, exp_d);
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.io_rden  = 1'b0;
      #2;
      chk("rst_in_ready",  bus.in_ready,  1);
      chk("rst_read_EF",   bus.read_EF,   0);
      chk("rst_level",     bus.level,     0);
      chk("rst_read_data", bus.read_data, 0);
      chk("rst_underflow", bus.underflow, 0);
      #8 reset_n = 1'b1;
      tick();

      // Fill to full, then hold a fifth word that must be refused
      push_word(36'h11);
      chk("push1_read_EF", bus.read_EF, 1);
      chk("push1_level",   bus.level,   1);
      push_word(36'h22);
      push_word(36'h33);
      push_word(36'h44);
      chk("full_level",    bus.level,    4);
      chk("full_in_ready", bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 36'h99;
      tick();
      tick();
      bus.in_valid = 1'b0;
      chk("full_hold_level", bus.level, 4);

      pop_word("drain0", 36'h11);
      chk("drain0_level", bus.level, 3);
      chk("drain0_in_ready", bus.in_ready, 1);
      pop_word("drain1", 36'h22);
      pop_word("drain2", 36'h33);
      pop_word("drain3", 36'h44);
      chk("drained_read_EF", bus.read_EF, 0);
      chk("drained_level",   bus.level,   0);

      // Empty pop: nothing moves, sticky flag follows the build option
      pop_word("empty_pop_data", 36'h44);
      chk("empty_pop_level", bus.level, 0);
      chk("empty_pop_uf",    bus.underflow, EXP_UF);
      tick();
      chk("empty_pop_uf_sticky", bus.underflow, EXP_UF);

      // Push and pop together on empty: the pop is ignored, the push lands
      bus.in_valid = 1'b1;
      bus.in_data  = 36'h55;
      bus.io_rden  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.io_rden  = 1'b0;
      chk("emp_pp_level",   bus.level,     1);
      chk("emp_pp_read_EF", bus.read_EF,   1);
      chk("emp_pp_data",    bus.read_data, 36'h44);
      pop_word("emp_pp_pop", 36'h55);
      chk("emp_pp_after_level", bus.level, 0);

      // Streaming at level 1 across several pointer wraps
      push_word(36'h100);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 36'h101 + 36'(i);
         bus.io_rden  = 1'b1;
         tick();
         chk($sformatf("wrap_data_%0d", i), bus.read_data, 36'h100 + 64'(i));
         chk($sformatf("wrap_level_%0d", i), bus.level, 1);
      end
      bus.in_valid = 1'b0;
      bus.io_rden  = 1'b0;
      pop_word("wrap_tail", 36'h10A);

      // Full with push and pop together: only the pop happens
      push_word(36'hA0);
      push_word(36'hA1);
      push_word(36'hA2);
      push_word(36'hA3);
      bus.in_valid = 1'b1;
      bus.in_data  = 36'hEE;
      bus.io_rden  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.io_rden  = 1'b0;
      chk("full_pp_data",     bus.read_data, 36'hA0);
      chk("full_pp_level",    bus.level,     3);
      chk("full_pp_in_ready", bus.in_ready,  1);
      pop_word("full_pp_d1", 36'hA1);
      pop_word("full_pp_d2", 36'hA2);
      pop_word("full_pp_d3", 36'hA3);
      chk("full_pp_empty", bus.read_EF, 0);

      // Reset mid-stream with three words buffered
      push_word(36'h71);
      push_word(36'h72);
      push_word(36'h73);
      chk("pre_rst_level", bus.level, 3);
      chk("pre_rst_uf",    bus.underflow, EXP_UF);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_read_EF",   bus.read_EF,   0);
      chk("mid_rst_level",     bus.level,     0);
      chk("mid_rst_in_ready",  bus.in_ready,  1);
      chk("mid_rst_read_data", bus.read_data, 0);
      chk("mid_rst_uf",        bus.underflow, 0);
      #2 reset_n = 1'b1;
      tick();
      push_word(36'h88);
      pop_word("post_rst_pop", 36'h88);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
